// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin push arbiter in front of a shared fifo
// plus a registered valid/ready output stage draining the fifo head.
module fifo_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    input  logic                    fifo_full,
    input  logic                    fifo_empty,
    input  logic [WIDTH-1:0]        fifo_data_out,
    output logic                    fifo_push,
    output logic                    fifo_pop,
    output logic [WIDTH-1:0]        fifo_data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LW-1:0]    last_gnt_q, last_gnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             found;
    int               idx;

    // Rotating-priority search starting just after the last winner
    always_comb begin
        gnt          = '0;
        fifo_push    = 1'b0;
        fifo_data_in = '0;
        last_gnt_d   = last_gnt_q;
        found        = 1'b0;
        idx          = 0;
        if (!rst && !fifo_full && |req) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = int'(last_gnt_q) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!found && req[idx]) begin
                    found        = 1'b1;
                    gnt[idx]     = 1'b1;
                    fifo_push    = 1'b1;
                    fifo_data_in = req_data[idx*WIDTH +: WIDTH];
                    last_gnt_d   = LW'(idx);
                end
            end
        end
    end

    // Pop whenever the output register is free or being consumed
    always_comb begin
        fifo_pop    = !rst && !fifo_empty && (!out_valid_q || out_ready);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (fifo_pop) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_data_out;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q  <= LW'(NREQ - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: directed bench with a depth-8 fifo model,
// a queue-based reference model and literal pins on key sequences.
module tb_fifo_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WIDTH-1:0]      fifo_data_out;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [WIDTH-1:0]      fifo_data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;

    fifo_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_push(fifo_push),
        .fifo_pop(fifo_pop), .fifo_data_in(fifo_data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // fifo shared with the scheduler (same clk / rst)
    logic [WIDTH-1:0] fmem [DEPTH];
    logic [2:0]       fwp, frp;
    int               fcnt;

    always @(posedge clk) begin
        if (rst) begin
            fwp  <= '0;
            frp  <= '0;
            fcnt <= 0;
        end else begin
            if (fifo_push) begin
                fmem[fwp] <= fifo_data_in;
                fwp       <= fwp + 3'd1;
            end
            if (fifo_pop) frp <= frp + 3'd1;
            fcnt <= fcnt + (fifo_push ? 1 : 0) - (fifo_pop ? 1 : 0);
        end
    end

    assign fifo_full     = (fcnt >= DEPTH);
    assign fifo_empty    = (fcnt == 0);
    assign fifo_data_out = fmem[frp];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // producers: per-producer word lists
    logic [WIDTH-1:0] pmem [NREQ][16];
    int               phead [NREQ];
    int               ptail [NREQ];
    logic [NREQ-1:0]  en;
    logic [NREQ-1:0]  gseen;

    // reference model state and logs
    int               m_last;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] sb [$];
    bit               armed = 0;
    int               cyc = 0;
    int               push_cycles [$];
    logic [NREQ-1:0]  push_gnts [$];
    int               pop_cycles [$];
    int               acc_cycles [$];
    logic [WIDTH-1:0] acc_words [$];

    // compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        int w;
        logic [NREQ-1:0] eg;
        logic [WIDTH-1:0] ed;
        logic ep;
        cyc++;
        w = -1;
        if (!rst && !fifo_full) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (w < 0 && req[c]) w = c;
            end
        end
        eg = '0;
        ed = '0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            ed    = req_data[w*WIDTH +: WIDTH];
        end
        ep = !rst && (fcnt > 0) && (!m_valid || out_ready);
        if (armed) begin
            chk("gnt", 32'(gnt), 32'(eg));
            chk("fifo_push", 32'(fifo_push), 32'(w >= 0));
            chk("fifo_data_in", 32'(fifo_data_in), 32'(ed));
            chk("fifo_pop", 32'(fifo_pop), 32'(ep));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data", 32'(out_data), 32'(m_data));
            if (!rst && m_valid && out_ready) begin
                acc_cycles.push_back(cyc);
                acc_words.push_back(out_data);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL order: got %0h expected none", out_data);
                end else begin
                    chk("order", 32'(out_data), 32'(sb.pop_front()));
                end
            end
            if (fifo_pop) pop_cycles.push_back(cyc);
        end
        if (rst) begin
            m_last  = NREQ - 1;
            m_valid = 1'b0;
            m_data  = '0;
            sb.delete();
            gseen   = '0;
            armed   = 1;
        end else begin
            gseen = gnt;
            if (ep) begin
                m_valid = 1'b1;
                m_data  = fifo_data_out;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (w >= 0) begin
                sb.push_back(ed);
                m_last = w;
                push_cycles.push_back(cyc);
                push_gnts.push_back(eg);
            end
        end
    end

    task automatic drive();
        req      = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (en[i] && phead[i] < ptail[i]) begin
                req[i] = 1'b1;
                req_data[i*WIDTH +: WIDTH] = pmem[i][phead[i]];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (gseen[i] && phead[i] < ptail[i]) phead[i]++;
        drive();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input int p, input logic [WIDTH-1:0] wd);
        pmem[p][ptail[p]] = wd;
        ptail[p]++;
    endtask

    task automatic clear_logs();
        push_cycles.delete();
        push_gnts.delete();
        pop_cycles.delete();
        acc_cycles.delete();
        acc_words.delete();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        drive();
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
        drive();
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        en        = '0;
        out_ready = 1'b0;
        gseen     = '0;
        m_last    = NREQ - 1;
        m_valid   = 1'b0;
        m_data    = '0;
        for (int i = 0; i < NREQ; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        drive();

        // 1: all producers requesting, consumer always ready
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        for (int i = 0; i < NREQ; i++)
            for (int n = 1; n <= 3; n++) load(i, 8'(i*16 + n));
        en        = 4'b1111;
        out_ready = 1'b1;
        drive();
        ticks(16);
        chk("t1_g0", 32'(push_gnts[0]), 32'h1);
        chk("t1_g1", 32'(push_gnts[1]), 32'h2);
        chk("t1_g2", 32'(push_gnts[2]), 32'h4);
        chk("t1_g3", 32'(push_gnts[3]), 32'h8);
        chk("t1_g4", 32'(push_gnts[4]), 32'h1);
        chk("t1_lat", 32'(acc_cycles[0]), 32'(push_cycles[0] + 2));
        chk("t1_w0", 32'(acc_words[0]), 32'h01);
        chk("t1_w1", 32'(acc_words[1]), 32'h11);
        chk("t1_w3", 32'(acc_words[3]), 32'h31);
        chk("t1_w4", 32'(acc_words[4]), 32'h02);
        chk("t1_gap", 32'(acc_cycles[4]), 32'(acc_cycles[0] + 4));

        // 2: two producers alternate, then a lone re-requesting producer
        do_reset();
        for (int n = 1; n <= 3; n++) begin
            load(0, 8'(n));
            load(2, 8'(8'h20 + n));
        end
        load(3, 8'h31);
        load(3, 8'h32);
        en        = 4'b0101;
        out_ready = 1'b1;
        drive();
        ticks(4);
        chk("t2_g0", 32'(push_gnts[0]), 32'h1);
        chk("t2_g1", 32'(push_gnts[1]), 32'h4);
        chk("t2_g2", 32'(push_gnts[2]), 32'h1);
        chk("t2_g3", 32'(push_gnts[3]), 32'h4);
        clear_logs();
        en = 4'b1000;
        drive();
        ticks(6);
        chk("t2_lone_n", 32'(push_gnts.size()), 32'd2);
        chk("t2_lone_a", 32'(push_gnts[0]), 32'h8);
        chk("t2_lone_b", 32'(push_gnts[1]), 32'h8);
        chk("t2_lone_c", 32'(push_cycles[1]), 32'(push_cycles[0] + 1));

        // 3: stalled consumer fills the fifo and the output register
        do_reset();
        for (int n = 1; n <= 9; n++) load(0, 8'(n));
        en = 4'b0001;
        drive();
        ticks(14);
        chk("t3_pushes", 32'(push_cycles.size()), 32'd9);
        chk("t3_full", 32'(fifo_full), 32'd1);
        chk("t3_hold", 32'(out_data), 32'd1);

        // 4: more requests wait on a full fifo, then drain
        load(1, 8'h41);
        load(1, 8'h42);
        load(2, 8'h81);
        en = 4'b0111;
        drive();
        ticks(3);
        chk("t4_nopush", 32'(push_cycles.size()), 32'd9);
        chk("t4_gnt0", 32'(gnt), 32'd0);
        pop_cycles.delete();
        acc_cycles.delete();
        acc_words.delete();
        out_ready = 1'b1;
        ticks(20);
        chk("t4_resume", 32'(push_cycles[9]), 32'(pop_cycles[0] + 1));
        chk("t4_nacc", 32'(acc_words.size()), 32'd12);
        for (int i = 0; i < 9; i++)
            chk("t4_word", 32'(acc_words[i]), 32'(i + 1));
        chk("t4_nogap", 32'(acc_cycles[8]), 32'(acc_cycles[0] + 8));
        chk("t4_w9", 32'(acc_words[9]), 32'h41);
        chk("t4_w10", 32'(acc_words[10]), 32'h81);
        chk("t4_w11", 32'(acc_words[11]), 32'h42);

        // 5: output word held under backpressure
        do_reset();
        load(2, 8'h55);
        load(2, 8'hAA);
        en = 4'b0100;
        drive();
        ticks(4);
        for (int i = 0; i < 5; i++) begin
            chk("t5_valid", 32'(out_valid), 32'd1);
            chk("t5_data", 32'(out_data), 32'h55);
            chk("t5_nopop", 32'(fifo_pop), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t5_pop", 32'(fifo_pop), 32'd1);
        tick();
        out_ready = 1'b0;
        #1;
        chk("t5_next_v", 32'(out_valid), 32'd1);
        chk("t5_next_d", 32'(out_data), 32'hAA);

        // 6: reset pulse in the middle of a stream
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int n = 1; n <= 6; n++) load(i, 8'(i*16 + n));
        en        = 4'b1111;
        out_ready = 1'b1;
        drive();
        ticks(5);
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'd0);
        chk("t6_rst_pop", 32'(fifo_pop), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_valid0", 32'(out_valid), 32'd0);
        chk("t6_restart", 32'(gnt), 32'h1);
        ticks(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
